// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcode and FSM state encodings,
// plus the multiplier step-count helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_AND   = 3'b001,
    OP_NOT   = 3'b010,
    OP_PASSA = 3'b011,
    OP_SUB   = 3'b100,
    OP_XOR   = 3'b101,
    OP_MUL   = 3'b110,
    OP_SHL   = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

  // One shift-add step per operand bit.
  function automatic int mul_steps(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, returns the
// low WIDTH bits of the unsigned product; o_product is valid on the last step.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign o_last     = (r_cnt == CW'(1));
  // The final accumulation is exposed combinationally so the caller can
  // register the product on the same edge that ends the iteration.
  assign o_product  = w_acc_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CW'(mul_steps(WIDTH));
    end else if (i_step && (r_cnt != '0)) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and NZP/carry flags.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL reports illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUK,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       nzp,
  output logic             carry,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_t          w_op;
  alu_state_t       r_state;
  alu_state_t       w_state_next;
  logic             w_accept;
  logic             w_start_mul;
  logic             w_mul_last;
  logic             w_load;
  logic             w_sub;
  logic             w_cout;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_result;
  logic             w_res_carry;
  logic             w_res_illegal;
  logic [WIDTH-1:0] r_out;
  logic [2:0]       r_nzp;
  logic             r_carry;
  logic             r_illegal;

  assign w_op      = alu_op_t'(ALUK);
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;

  // ADD and SUB share one adder: SUB feeds ~B with carry-in 1.
  assign w_sub   = (w_op == OP_SUB);
  assign w_b_sel = w_sub ? ~B : B;
  assign {w_cout, w_sum} = {1'b0, A} + {1'b0, w_b_sel} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    w_res         = '0;
    w_res_carry   = 1'b0;
    w_res_illegal = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res       = w_sum;
        w_res_carry = w_cout;
      end
      OP_AND:   w_res = A & B;
      OP_NOT:   w_res = ~A;
      OP_PASSA: w_res = A;
      OP_XOR:   w_res = A ^ B;
      OP_SHL:   w_res = A << B[SHW-1:0];
      OP_MUL: begin
`ifndef ALU_MUL_EN
        w_res_illegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_mul_prod;

  assign w_start_mul = w_accept && (w_op == OP_MUL);

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_start   (w_start_mul),
    .i_step    (r_state == ST_BUSY),
    .i_a       (A),
    .i_b       (B),
    .o_last    (w_mul_last),
    .o_product (w_mul_prod)
  );

  assign w_result = (r_state == ST_BUSY) ? w_mul_prod : w_res;
`else
  assign w_start_mul = 1'b0;
  assign w_mul_last  = 1'b1;
  assign w_result    = w_res;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_start_mul ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_mul_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_next = w_start_mul ? ST_BUSY : ST_DONE;
          else          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Results are captured on single-cycle accept or on the last multiply step.
  assign w_load = (w_accept && !w_start_mul) || ((r_state == ST_BUSY) && w_mul_last);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out     <= '0;
      r_nzp     <= 3'b000;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_out     <= w_result;
      r_nzp     <= {w_result[WIDTH-1], (w_result == '0),
                    (!w_result[WIDTH-1] && (w_result != '0))};
      r_carry   <= (r_state == ST_BUSY) ? 1'b0 : w_res_carry;
      r_illegal <= (r_state == ST_BUSY) ? 1'b0 : w_res_illegal;
    end
  end

  assign out     = r_out;
  assign nzp     = r_nzp;
  assign carry   = r_carry;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=16 and WIDTH=8; expectations are
// hand-computed and queued at issue, a per-instance monitor compares results.
module tb_alu_pipe;

  localparam logic [2:0] C_ADD = 3'b000, C_AND = 3'b001, C_NOT = 3'b010, C_PASSA = 3'b011;
  localparam logic [2:0] C_SUB = 3'b100, C_XOR = 3'b101, C_MUL = 3'b110, C_SHL = 3'b111;

  typedef struct packed {
    logic [15:0] out;
    logic [2:0]  nzp;
    logic        carry;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, carry_16, ill_16;
  logic [2:0]  aluk_16, nzp_16;
  logic [15:0] a_16, b_16, out_16;

  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, carry_8, ill_8;
  logic [2:0]  aluk_8, nzp_8;
  logic [7:0]  a_8, b_8, out_8;

  exp_t q16[$];
  exp_t q8[$];
  exp_t m16_e;
  exp_t m8_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pop16  = 0;
  int   c0;

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .ALUK(aluk_16), .A(a_16), .B(b_16), .out_valid(out_valid_16),
    .out_ready(out_ready_16), .out(out_16), .nzp(nzp_16), .carry(carry_16),
    .illegal(ill_16)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .ALUK(aluk_8), .A(a_8), .B(b_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .out(out_8), .nzp(nzp_8), .carry(carry_8),
    .illegal(ill_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic [2:0] en, input logic ec, input logic ei);
    in_valid_16 = 1'b1;
    aluk_16     = op;
    a_16        = a;
    b_16        = b;
    q16.push_back({eo, en, ec, ei});
  endtask

  task automatic idle16();
    in_valid_16 = 1'b0;
    aluk_16     = C_SHL;
    a_16        = 16'hDEAD;
    b_16        = 16'hBEEF;
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic [2:0] en, input logic ec, input logic ei);
    in_valid_8 = 1'b1;
    aluk_8     = op;
    a_8        = a;
    b_8        = b;
    q8.push_back({8'h00, eo, en, ec, ei});
  endtask

  task automatic idle8();
    in_valid_8 = 1'b0;
    aluk_8     = C_SHL;
    a_8        = 8'hA5;
    b_8        = 8'h5A;
  endtask

  // Monitors: compare the head of the queue whenever a result is presented,
  // retire it only when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid_16) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected16: got out=0x%0h with no result expected", out_16);
      end else begin
        m16_e = q16[0];
        check("out16", {16'h0, out_16}, {16'h0, m16_e.out});
        check("nzp16", {29'h0, nzp_16}, {29'h0, m16_e.nzp});
        check("carry16", {31'h0, carry_16}, {31'h0, m16_e.carry});
        check("illegal16", {31'h0, ill_16}, {31'h0, m16_e.ill});
        if (out_ready_16) begin
          void'(q16.pop_front());
          n_pop16++;
          $display("txn w16 out=0x%04h nzp=%03b carry=%0b illegal=%0b", out_16, nzp_16, carry_16, ill_16);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected8: got out=0x%0h with no result expected", out_8);
      end else begin
        m8_e = q8[0];
        check("out8", {24'h0, out_8}, {16'h0, m8_e.out});
        check("nzp8", {29'h0, nzp_8}, {29'h0, m8_e.nzp});
        check("carry8", {31'h0, carry_8}, {31'h0, m8_e.carry});
        check("illegal8", {31'h0, ill_8}, {31'h0, m8_e.ill});
        if (out_ready_8) begin
          void'(q8.pop_front());
          $display("txn w8 out=0x%02h nzp=%03b carry=%0b illegal=%0b", out_8, nzp_8, carry_8, ill_8);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle16();
    idle8();
    out_ready_16 = 1'b1;
    out_ready_8  = 1'b1;
    repeat (3) step();
    check("rst_hold_valid", {31'h0, out_valid_16}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready16", {31'h0, in_ready_16}, 32'd1);
    check("rst_out_valid16", {31'h0, out_valid_16}, 32'd0);
    check("rst_out16", {16'h0, out_16}, 32'd0);
    check("rst_nzp16", {29'h0, nzp_16}, 32'd0);
    check("rst_carry16", {31'h0, carry_16}, 32'd0);
    check("rst_illegal16", {31'h0, ill_16}, 32'd0);
    check("rst_in_ready8", {31'h0, in_ready_8}, 32'd1);
    step();

    // Single-cycle ops with one-cycle latency
    send16(C_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0, 1'b0);
    step(); idle16();
    @(negedge clk);
    check("lat_add", {31'h0, out_valid_16}, 32'd1);
    step();
    send16(C_SUB, 16'h0005, 16'h0005, 16'h0000, 3'b010, 1'b1, 1'b0);
    step(); idle16(); step();
    send16(C_SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b100, 1'b0, 1'b0);
    step(); idle16(); step();
    send16(C_PASSA, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1'b0, 1'b0);
    step(); idle16(); step();

    // Multiply: operands scrambled right after acceptance
`ifdef ALU_MUL_EN
    send16(C_MUL, 16'h0012, 16'h0034, 16'h03A8, 3'b001, 1'b0, 1'b0);
    step(); idle16();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mul_busy_valid", {31'h0, out_valid_16}, 32'd0);
      check("mul_busy_ready", {31'h0, in_ready_16}, 32'd0);
      step();
    end
    @(negedge clk);
    check("mul_done_valid", {31'h0, out_valid_16}, 32'd1);
    step();
`else
    send16(C_MUL, 16'h0012, 16'h0034, 16'h0000, 3'b010, 1'b0, 1'b1);
    step(); idle16();
    @(negedge clk);
    check("mul_illegal_lat", {31'h0, out_valid_16}, 32'd1);
    step();
`endif

    // Back-to-back single-cycle ops
    c0 = n_pop16;
    send16(C_XOR, 16'h00F0, 16'h0FF0, 16'h0F00, 3'b001, 1'b0, 1'b0);
    step();
    send16(C_SHL, 16'h0001, 16'h0004, 16'h0010, 3'b001, 1'b0, 1'b0);
    step();
    send16(C_AND, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1'b0, 1'b0);
    step(); idle16();
    step();
    check("b2b_count", n_pop16 - c0, 32'd3);

    // Consumer stall: result held, no new request accepted
    out_ready_16 = 1'b0;
    send16(C_NOT, 16'h0000, 16'h0000, 16'hFFFF, 3'b100, 1'b0, 1'b0);
    step(); idle16();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, out_valid_16}, 32'd1);
      check("stall_in_ready", {31'h0, in_ready_16}, 32'd0);
      step();
    end
    out_ready_16 = 1'b1;
    step();
    @(negedge clk);
    check("stall_release", {31'h0, out_valid_16}, 32'd0);
    step();

    // Reset while a result waits in DONE
    out_ready_16 = 1'b0;
    send16(C_PASSA, 16'h8001, 16'h0000, 16'h8001, 3'b100, 1'b0, 1'b0);
    step(); idle16();
    step();
    rst_n = 1'b0;
    #1;
    check("rstdone_valid", {31'h0, out_valid_16}, 32'd0);
    check("rstdone_out", {16'h0, out_16}, 32'd0);
    q16.delete();
    step();
    rst_n = 1'b1;
    out_ready_16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstdone_no_stale", {31'h0, out_valid_16}, 32'd0);
      step();
    end

`ifdef ALU_MUL_EN
    // Reset in the middle of a multiply
    send16(C_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 3'b100, 1'b0, 1'b0);
    step(); idle16();
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("rstbusy_valid", {31'h0, out_valid_16}, 32'd0);
    check("rstbusy_out", {16'h0, out_16}, 32'd0);
    q16.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rstbusy_no_stale", {31'h0, out_valid_16}, 32'd0);
      step();
    end
`endif

    // WIDTH=8 instance
    send8(C_ADD, 8'hFF, 8'h01, 8'h00, 3'b010, 1'b1, 1'b0);
    step(); idle8(); step();
    send8(C_SUB, 8'h10, 8'h20, 8'hF0, 3'b100, 1'b0, 1'b0);
    step(); idle8(); step();
    send8(C_SHL, 8'h81, 8'h09, 8'h02, 3'b001, 1'b0, 1'b0);
    step(); idle8(); step();
`ifdef ALU_MUL_EN
    send8(C_MUL, 8'h0C, 8'h0B, 8'h84, 3'b100, 1'b0, 1'b0);
    step(); idle8();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul8_busy_valid", {31'h0, out_valid_8}, 32'd0);
      step();
    end
    @(negedge clk);
    check("mul8_done_valid", {31'h0, out_valid_8}, 32'd1);
    step();
`else
    send8(C_MUL, 8'h0C, 8'h0B, 8'h00, 3'b010, 1'b0, 1'b1);
    step(); idle8();
    @(negedge clk);
    check("mul8_illegal_lat", {31'h0, out_valid_8}, 32'd1);
    step();
`endif

    repeat (3) step();
    check("q16_drained", q16.size(), 32'd0);
    check("q8_drained", q8.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
